// File: rtl/div_collect_pkg.sv
// Shared definitions for the divider result collector.
// Holds the default operand widths and the layout of one collected result.
package div_collect_pkg;

    localparam int DEF_Z_WIDTH = 16;
    localparam int DEF_D_WIDTH = DEF_Z_WIDTH / 2;
    localparam int DEF_Q_WIDTH = DEF_D_WIDTH + 1;

    // One collected divider result together with the operands that produced it
    typedef struct packed {
        logic [DEF_Z_WIDTH-1:0] z;
        logic [DEF_D_WIDTH-1:0] d;
        logic [DEF_Q_WIDTH-1:0] q;
        logic [DEF_Q_WIDTH-1:0] s;
        logic                   ovf;
        logic                   div0;
        logic                   mismatch;
    } rec_t;

endpackage

// File: rtl/div_collect_fifo.sv
// Small synchronous FIFO of result records.
// Pointers carry one extra wrap bit so full and empty are told apart without a
// separate occupancy register. The head reads as all-zero while the FIFO is empty.
module div_collect_fifo
    import div_collect_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = rec_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  T                         wdata_i,
    output T                         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wr_q, wr_d;
    logic [AW:0]    rd_q, rd_d;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;

    // A push into a full FIFO is only taken when the head leaves on the same edge
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    // Next-state pointer arithmetic
    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents are only meaningful between the read and write pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/div_result_collector.sv
// Collects results from the pipelined divider and re-attaches the operands
// that produced them. Every issued operand pair travels down a tag delay line
// as long as the divider latency; when it reaches the tail the divider output
// on that cycle belongs to it and the pair is written into a result FIFO.
// Issue is credit-limited so the FIFO can always absorb what is in flight.
// Build option: define DIV_COLLECT_CHECK_EN to recompute each result and flag
// disagreements on out_mismatch; without it out_mismatch is tied low.
module div_result_collector
    import div_collect_pkg::*;
#(
    parameter int Z_WIDTH    = DEF_Z_WIDTH,
    parameter int D_WIDTH    = Z_WIDTH / 2,
    parameter int PIPELINE   = D_WIDTH + 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Z_WIDTH-1:0] in_z,
    input  logic [D_WIDTH-1:0] in_d,
    input  logic [D_WIDTH:0]   div_q,
    input  logic [D_WIDTH:0]   div_s,
    input  logic               div_ovf,
    input  logic               div_div0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Z_WIDTH-1:0] out_z,
    output logic [D_WIDTH-1:0] out_d,
    output logic [D_WIDTH:0]   out_q,
    output logic [D_WIDTH:0]   out_s,
    output logic               out_ovf,
    output logic               out_div0,
    output logic               out_mismatch,
    output logic               overrun_err
);

    localparam int Q_WIDTH = D_WIDTH + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [Z_WIDTH-1:0] z;
        logic [D_WIDTH-1:0] d;
        logic [Q_WIDTH-1:0] q;
        logic [Q_WIDTH-1:0] s;
        logic               ovf;
        logic               div0;
        logic               mismatch;
    } entry_t;

    logic [PIPELINE-1:0] vld_q;
    logic [Z_WIDTH-1:0]  z_q  [PIPELINE];
    logic [D_WIDTH-1:0]  dv_q [PIPELINE];
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic                overrun_q, overrun_d;

    logic                accept;
    logic                tail_vld;
    logic                pop;
    logic                push_ok;
    logic                push_drop;
    logic                mism;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    entry_t              wr_ent;
    entry_t              head;

`ifdef DIV_COLLECT_CHECK_EN
    // Reference division; results flagged by the divider itself are not judged
    function automatic logic golden_mismatch(
        input logic [Z_WIDTH-1:0] z,
        input logic [D_WIDTH-1:0] d,
        input logic [Q_WIDTH-1:0] q,
        input logic [Q_WIDTH-1:0] s,
        input logic               ovf,
        input logic               div0
    );
        logic [Z_WIDTH-1:0] dz;
        logic [Z_WIDTH-1:0] qf;
        logic [Z_WIDTH-1:0] rf;
        if (ovf || div0 || (d == '0)) begin
            return 1'b0;
        end
        dz = Z_WIDTH'(d);
        qf = z / dz;
        rf = z - dz * qf;
        return (Q_WIDTH'(qf) != q) || (Q_WIDTH'(rf) != s);
    endfunction
`endif

    // Credits come from registered state only, so in_ready never depends on out_ready
    assign in_ready = (int'(inflight_q) + int'(fifo_count)) < FIFO_DEPTH;
    assign accept   = in_valid & in_ready;
    assign tail_vld = vld_q[PIPELINE-1];
    assign pop      = out_valid & out_ready;

    // The credit bound keeps this from happening; if it does the result is lost and flagged
    assign push_ok   = tail_vld & (~fifo_full | pop);
    assign push_drop = tail_vld & fifo_full & ~pop;

`ifdef DIV_COLLECT_CHECK_EN
    assign mism = golden_mismatch(z_q[PIPELINE-1], dv_q[PIPELINE-1], div_q, div_s, div_ovf, div_div0);
`else
    assign mism = 1'b0;
`endif

    // Valid bits of the tag delay line; reset discards every tracked operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPELINE-2:0], accept};
        end
    end

    // Operand payload of the delay line, only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        z_q[0]  <= in_z;
        dv_q[0] <= in_d;
        for (int i = 1; i < PIPELINE; i++) begin
            z_q[i]  <= z_q[i-1];
            dv_q[i] <= dv_q[i-1];
        end
    end

    // In-flight count and sticky overrun flag next-state
    always_comb begin
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(tail_vld);
        overrun_d  = overrun_q | (in_valid & ~in_ready) | push_drop;
    end

    // In-flight count and sticky overrun flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            overrun_q  <= overrun_d;
        end
    end

    // Pair the delay-line tail with the divider output of the same cycle
    always_comb begin
        wr_ent          = '0;
        wr_ent.z        = z_q[PIPELINE-1];
        wr_ent.d        = dv_q[PIPELINE-1];
        wr_ent.q        = div_q;
        wr_ent.s        = div_s;
        wr_ent.ovf      = div_ovf;
        wr_ent.div0     = div_div0;
        wr_ent.mismatch = mism;
    end

    div_collect_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (wr_ent),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid    = ~fifo_empty;
    assign out_z        = head.z;
    assign out_d        = head.d;
    assign out_q        = head.q;
    assign out_s        = head.s;
    assign out_ovf      = head.ovf;
    assign out_div0     = head.div0;
    assign out_mismatch = head.mismatch;
    assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_div_result_collector.sv
// Directed bench for div_result_collector with a behavioural divider model
// that answers each accepted operand pair PL clocks later.
`timescale 1ns/1ps
module tb_div_result_collector;

    localparam int ZW = 16;
    localparam int DW = 8;
    localparam int QW = 9;
    localparam int PL = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [ZW-1:0] in_z = '0;
    logic [DW-1:0] in_d = '0;
    logic [QW-1:0] div_q, div_s;
    logic          div_ovf, div_div0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [ZW-1:0] out_z;
    logic [DW-1:0] out_d;
    logic [QW-1:0] out_q, out_s;
    logic          out_ovf, out_div0, out_mismatch, overrun_err;

    int n_pass = 0;
    int n_total = 0;
    bit bad_q = 1'b0;

    typedef struct {
        logic [ZW-1:0] z;
        logic [DW-1:0] d;
        logic [QW-1:0] q;
        logic [QW-1:0] s;
        logic          ovf;
        logic          div0;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    div_result_collector #(
        .Z_WIDTH    (ZW),
        .D_WIDTH    (DW),
        .PIPELINE   (PL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .in_d         (in_d),
        .div_q        (div_q),
        .div_s        (div_s),
        .div_ovf      (div_ovf),
        .div_div0     (div_div0),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_d        (out_d),
        .out_q        (out_q),
        .out_s        (out_s),
        .out_ovf      (out_ovf),
        .out_div0     (out_div0),
        .out_mismatch (out_mismatch),
        .overrun_err  (overrun_err)
    );

    // Divider stand-in: fixed latency, not reset, answers only what the DUT accepted
    bit          pv [PL];
    bit [ZW-1:0] pz [PL];
    bit [DW-1:0] pd [PL];

    always @(posedge clk) begin
        for (int i = PL - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pz[i] <= pz[i-1];
            pd[i] <= pd[i-1];
        end
        pv[0] <= in_valid & in_ready;
        pz[0] <= in_z;
        pd[0] <= in_d;
    end

    always_comb begin
        int zz, dd, qq;
        zz = int'(pz[PL-1]);
        dd = int'(pd[PL-1]);
        qq = 0;
        div_q = '0;
        div_s = '0;
        div_ovf = 1'b0;
        div_div0 = 1'b0;
        if (dd == 0) begin
            div_div0 = 1'b1;
        end else begin
            qq = zz / dd;
            if (qq > (1 << QW) - 1) begin
                div_ovf = 1'b1;
            end else begin
                div_q = bad_q ? QW'(4) : QW'(qq);
                div_s = QW'(zz % dd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_head(input string tag, input vec_t v);
        chk({tag, "_z"}, 32'(out_z), 32'(v.z));
        chk({tag, "_d"}, 32'(out_d), 32'(v.d));
        chk({tag, "_q"}, 32'(out_q), 32'(v.q));
        chk({tag, "_s"}, 32'(out_s), 32'(v.s));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
        chk({tag, "_div0"}, 32'(out_div0), 32'(v.div0));
        chk({tag, "_mismatch"}, 32'(out_mismatch), 32'd0);
    endtask

    // Called at a falling edge; waits (bounded) for a credit, then issues for one cycle
    task automatic issue(input logic [ZW-1:0] z, input logic [DW-1:0] d);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("issue_credit", 32'(in_ready), 32'd1);
        if (in_ready) begin
            in_z = z;
            in_d = d;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, idx, acc, seen;
        vec_t v;

        tbl[0] = '{z: 16'd50,    d: 8'd10,  q: 9'd5,  s: 9'd0, ovf: 1'b0, div0: 1'b0};
        tbl[1] = '{z: 16'd173,   d: 8'd11,  q: 9'd15, s: 9'd8, ovf: 1'b0, div0: 1'b0};
        tbl[2] = '{z: 16'd296,   d: 8'd12,  q: 9'd24, s: 9'd8, ovf: 1'b0, div0: 1'b0};
        tbl[3] = '{z: 16'd419,   d: 8'd13,  q: 9'd32, s: 9'd3, ovf: 1'b0, div0: 1'b0};
        tbl[4] = '{z: 16'd77,    d: 8'd0,   q: 9'd0,  s: 9'd0, ovf: 1'b0, div0: 1'b1};
        tbl[5] = '{z: 16'd60000, d: 8'd10,  q: 9'd0,  s: 9'd0, ovf: 1'b1, div0: 1'b0};
        tbl[6] = '{z: 16'd1000,  d: 8'd255, q: 9'd3,  s: 9'd235, ovf: 1'b0, div0: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_overrun", 32'(overrun_err), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_q", 32'(out_q), 32'd0);
        chk("rst_mismatch", 32'(out_mismatch), 32'd0);

        // Single op latency: out_valid appears PL clocks after the accepting edge
        in_z = tbl[0].z;
        in_d = tbl[0].d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(PL));
        check_head("single", tbl[0]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single_popped", 32'(out_valid), 32'd0);

        // Remaining table vectors issued as fast as credits allow, drained in order
        fork
            begin
                for (int i = 1; i < 7; i++) issue(tbl[i].z, tbl[i].d);
            end
            begin
                out_ready = 1'b1;
                idx = 1;
                cyc = 0;
                while (idx < 7 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid) begin
                        v = tbl[idx];
                        check_head($sformatf("vec%0d", idx), v);
                        idx++;
                    end
                end
                chk("vec_count", 32'(idx), 32'd7);
            end
        join
        @(negedge clk);
        out_ready = 1'b0;
        chk("vec_drained", 32'(out_valid), 32'd0);
        chk("vec_no_overrun", 32'(overrun_err), 32'd0);

        // Consumer stalled: credits run out after FD accepts
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_z = 16'(100 + 7 * i);
            in_d = 8'd7;
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stall_accepts", 32'(acc), 32'(FD));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("overrun_set", 32'(overrun_err), 32'd1);
        repeat (PL + 2) @(negedge clk);
        chk("stall_full_valid", 32'(out_valid), 32'd1);
        chk("stall_full_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < FD; k++) begin
            chk($sformatf("stall_z%0d", k), 32'(out_z), 32'(100 + 7 * k));
            chk($sformatf("stall_q%0d", k), 32'(out_q), 32'(14 + k));
            chk($sformatf("stall_s%0d", k), 32'(out_s), 32'd2);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("credit_back%0d", k), 32'(in_ready), 32'd1);
        end
        repeat (PL) @(negedge clk);
        chk("stall_no_extra", 32'(out_valid), 32'd0);
        chk("overrun_sticky", 32'(overrun_err), 32'd1);

        // Reset with operations in flight: nothing emerges afterwards
        for (int i = 0; i < 3; i++) issue(16'(200 + i), 8'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_overrun", 32'(overrun_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (PL + 8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("midrst_no_results", 32'(seen), 32'd0);

        // Divider returns a wrong quotient for 50/10
        bad_q = 1'b1;
        issue(16'd50, 8'd10);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bad_valid", 32'(out_valid), 32'd1);
        chk("bad_q", 32'(out_q), 32'd4);
`ifdef DIV_COLLECT_CHECK_EN
        chk("bad_mismatch", 32'(out_mismatch), 32'd1);
`else
        chk("bad_mismatch", 32'(out_mismatch), 32'd0);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        bad_q = 1'b0;
        chk("bad_popped", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_result_collector.md
Name: div_result_collector

Overview:
- Downstream neighbour of the pipelined divider (Z_WIDTH/D_WIDTH, latency D_WIDTH+4).
- Tracks every operand pair issued to the divider through a tag delay line that matches the divider latency.
- Captures the aligned divider result with its originating operands into a small FIFO, presented on a ready/valid port.
- Credit-based in_ready ensures no result is lost when the consumer stalls.

Parameters:
- Z_WIDTH, 16, dividend width.
- D_WIDTH, Z_WIDTH/2, divisor width; q/s are D_WIDTH+1 bits.
- PIPELINE, D_WIDTH+4, divider latency in clocks from operand issue to result.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair issued to divider this cycle.
- in_ready  out  1  issue permitted (credit available).
- in_z  in  Z_WIDTH  dividend issued.
- in_d  in  D_WIDTH  divisor issued.
- div_q  in  D_WIDTH+1  divider quotient.
- div_s  in  D_WIDTH+1  divider remainder.
- div_ovf  in  1  divider overflow flag.
- div_div0  in  1  divider divide-by-zero flag.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_z  out  Z_WIDTH  head: dividend.
- out_d  out  D_WIDTH  head: divisor.
- out_q  out  D_WIDTH+1  head: quotient.
- out_s  out  D_WIDTH+1  head: remainder.
- out_ovf  out  1  head: overflow.
- out_div0  out  1  head: divide-by-zero.
- out_mismatch  out  1  head: result differs from golden (see Optional Feature).
- overrun_err  out  1  sticky; in_valid seen while in_ready=0.

Behaviour:
- Reset (async assert, sync-released use): delay line valid bits 0; FIFO empty; in-flight count 0; out_valid=0; all out_* data 0; out_mismatch=0; overrun_err=0; in_ready=1 on the first cycle after release.
- Issue accepted = in_valid & in_ready. Accepted {z,d} enter stage 0 of a PIPELINE-deep delay line with valid bit 1. Otherwise valid bit 0.
- Alignment:
  - An operand accepted at edge t reaches the delay line tail at edge t+PIPELINE-1.
  - Combinationally pair it with div_* during cycle t+PIPELINE-1..t+PIPELINE.
  - Push into the FIFO at edge t+PIPELINE.
  - out_valid rises at edge t+PIPELINE at the earliest (empty FIFO, registered head).
- Push occurs only when the tail valid bit is 1. div_* are ignored when the tail valid bit is 0.
- Pop = out_valid & out_ready.
- Simultaneous push and pop on a full FIFO is legal. Simultaneous push and pop on an empty FIFO: the push is visible next cycle. No bypass.
- Credits:
  - inflight = number of valid delay-line stages; count = FIFO occupancy.
  - in_ready = (inflight + count) < FIFO_DEPTH, computed from registered state only. No combinational path from out_ready.
  - This bound guarantees a push is never attempted on a full FIFO.
  - Defensive rule: if a push arrives while full, drop it and set overrun_err.
- in_valid with in_ready=0: not tracked; overrun_err set, held until reset.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decoded from the MSB wrap.
- Reset mid-flight: all tracked operations are discarded. Divider results emerging afterwards are ignored (valid bits are 0).
- out_* hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro DIV_COLLECT_CHECK_EN.
- When defined:
  - At push, compute golden qc=z/d and sc=z-d*(z/d), truncated to D_WIDTH+1 bits.
  - Store mismatch = !ovf & !div0 & ((qc!=q)|(sc!=s)) with the entry; out_mismatch presents it.
  - With d=0 or ovf=1, mismatch=0.
- When undefined: out_mismatch tied 0; no divider logic synthesised.

Decomposition:
- Package div_collect_pkg: Z_WIDTH/D_WIDTH defaults, derived Q_WIDTH=D_WIDTH+1, result record struct {z,d,q,s,ovf,div0,mismatch}.
- Sub-module div_collect_fifo: parameterised synchronous FIFO of the record (push, pop, full, empty, count).

Test Plan:
- Issue z=50,d=10 at cycle 0, out_ready=1 -> out_valid at cycle 12 with out_q=5, out_s=0, out_ovf=0, out_div0=0.
- Issue (173,11),(296,12),(419,13) back-to-back -> three results in order: q=15,s=8; q=24,s=8; q=32,s=3.
- out_ready=0, issue every cycle -> in_ready drops after 4 accepts. Raising out_ready then pops 4 entries in order, and in_ready returns only as entries pop.
- Issue d=0 (divider flags div0) -> entry has out_div0=1 and out_mismatch=0.
- Drive in_valid=1 while in_ready=0 -> overrun_err=1, stays set; entry count unchanged.
- Assert rst_n low with 3 ops in flight -> out_valid=0, no entries ever appear afterwards.
- With DIV_COLLECT_CHECK_EN, force div_q=4 for z=50,d=10 -> out_mismatch=1.
